// File: rtl/register_bank_pkg.sv
// Purpose: shared state encoding and default widths for the register bank, datapath and ALU.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package register_bank_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_ADDR_W = 3;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

endpackage

// File: rtl/register_bank_clear_fsm.sv
// Purpose: sequences a whole-bank clear, one entry per cycle, with busy and a done pulse.
// Latency: busy rises 1 cycle after clear_all; 2**ADDR_W busy cycles; clear_done on the next cycle.
// Backpressure: none; clear_all is sampled only in IDLE, so requests during a clear are ignored.
module register_bank_clear_fsm
    import register_bank_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear_all,
    output logic              busy,
    output logic              clear_done,
    output logic              clear_we,
    output logic [ADDR_W-1:0] clear_addr
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_cnt;
    logic [ADDR_W-1:0] w_cnt_nxt;
    logic              r_done;
    logic              w_done_nxt;

    // State, counter and done-pulse registers; reset aborts any clear in progress silently.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_done  <= w_done_nxt;
        end
    end

    // Next-state logic: the last entry is detected by explicit compare, so the counter never needs a wrap bit.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_done_nxt  = 1'b0;
        case (r_state)
            IDLE: begin
                if (clear_all) begin
                    w_state_nxt = CLEAR;
                    w_cnt_nxt   = '0;
                end
            end
            CLEAR: begin
                if (r_cnt == LAST_ADDR) begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                    w_done_nxt  = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + ADDR_W'(1);
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    assign busy       = (r_state == CLEAR);
    assign clear_we   = busy;
    assign clear_addr = r_cnt;
    assign clear_done = r_done;

endmodule

// File: rtl/register_bank.sv
// Purpose: 2**ADDR_W x DATA_W register file, one sync write port, two async read ports, optional bypass/zero reg.
// Latency: writes land on the next edge; reads are combinational (same cycle with BYPASS=1).
// Backpressure: none; load/clr during a sequenced clear are dropped, busy flags that window.
module register_bank
    import register_bank_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              clr,
    input  logic [ADDR_W-1:0] clr_addr,
    input  logic              clear_all,
    input  logic [ADDR_W-1:0] rd_addr_a,
    output logic [DATA_W-1:0] rd_data_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [DATA_W-1:0] rd_data_b,
    output logic              busy,
    output logic              clear_done
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] r_mem [DEPTH];

    logic              w_busy;
    logic              w_clear_we;
    logic [ADDR_W-1:0] w_clear_addr;
    logic              w_wr_en;
    logic              w_clr_en;
    logic              w_clr_hits_wr;

    register_bank_clear_fsm #(
        .ADDR_W (ADDR_W)
    ) u_clear_fsm (
        .clk        (clk),
        .reset      (reset),
        .clear_all  (clear_all),
        .busy       (w_busy),
        .clear_done (clear_done),
        .clear_we   (w_clear_we),
        .clear_addr (w_clear_addr)
    );

    // Writes to entry 0 are dropped when it is hard-wired, so it stays at its reset value of 0.
    assign w_wr_en       = load && !w_busy && !((ZERO_REG != 0) && (wr_addr == '0));
    assign w_clr_en      = clr && !w_busy;
    assign w_clr_hits_wr = w_clr_en && (clr_addr == wr_addr);

    // Storage update: sequenced clear owns the array while busy; otherwise clr is applied after load so it wins a collision.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_clear_we) begin
            r_mem[w_clear_addr] <= '0;
        end else begin
            if (w_wr_en) begin
                r_mem[wr_addr] <= wr_data;
            end
            if (w_clr_en) begin
                r_mem[clr_addr] <= '0;
            end
        end
    end

    // One read port: stored value, then bypass, then zero-reg, then the whole-clear mask, in rising priority.
    function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] addr);
        logic [DATA_W-1:0] v;
        v = r_mem[addr];
        if ((BYPASS != 0) && load && (wr_addr == addr)) begin
            v = w_clr_hits_wr ? '0 : wr_data;
        end
        if ((ZERO_REG != 0) && (addr == '0)) begin
            v = '0;
        end
        if (w_busy) begin
            v = '0;
        end
        return v;
    endfunction

    // Port A read mux.
    always_comb begin
        rd_data_a = read_port(rd_addr_a);
    end

    // Port B read mux.
    always_comb begin
        rd_data_b = read_port(rd_addr_b);
    end

    assign busy = w_busy;

endmodule

// File: doc/register_bank.md
Name: register_bank

Overview:
- Parametrised successor to the 8x8 single-port register file used by the single-cycle datapath.
- Provides one synchronous write port and two asynchronous read ports (rs/rt style operand fetch).
- Optional write-to-read bypass and an optional hard-wired zero register.
- Whole-bank clear is a sequenced operation (one entry per cycle) with a busy indication, replacing the single-cycle clear-all.

Parameters:
- DATA_W, 8, width of each register in bits.
- ADDR_W, 3, address width; depth is fixed at 2**ADDR_W entries.
- BYPASS, 1, 1 = a same-cycle write is forwarded to a matching read port; 0 = read returns the stored value.
- ZERO_REG, 0, 1 = entry 0 always reads 0 and writes to it are discarded.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all entries and control state.
- load  in  1  write enable.
- wr_addr  in  ADDR_W  write address.
- wr_data  in  DATA_W  write data.
- clr  in  1  single-entry synchronous clear of clr_addr.
- clr_addr  in  ADDR_W  entry to clear.
- clear_all  in  1  start a sequenced whole-bank clear (level sampled in IDLE).
- rd_addr_a  in  ADDR_W  read address, port A.
- rd_data_a  out  DATA_W  read data, port A (combinational).
- rd_addr_b  in  ADDR_W  read address, port B.
- rd_data_b  out  DATA_W  read data, port B (combinational).
- busy  out  1  high while the sequenced clear is in progress.
- clear_done  out  1  one-cycle pulse on the cycle after the final entry is cleared.

Behaviour:
- reset asserted (any time, including mid-clear):
  - all entries = 0, state = IDLE, clear counter = 0.
  - busy = 0, clear_done = 0.
  - rd_data_a/b = 0 (or the bypass value, if applicable).
- FSM states are IDLE and CLEAR.
  - IDLE -> CLEAR on a clk edge with clear_all=1. Counter is set to 0 and busy goes high from the next cycle.
  - In CLEAR, each edge writes entry[counter] = 0 and increments the counter.
  - CLEAR -> IDLE on the edge that clears entry 2**ADDR_W-1. clear_done = 1 for exactly the following cycle.
  - A full clear takes 2**ADDR_W cycles of busy.
  - clear_all while already in CLEAR is ignored; there is no restart.
  - clear_all held high after completion starts a new clear on the cycle clear_done is high.
- Writes (IDLE only): on a rising edge with load=1, entry[wr_addr] = wr_data.
  - load during CLEAR is discarded; no queuing.
- Single clear (IDLE only): on a rising edge with clr=1, entry[clr_addr] = 0.
  - If clr and load target the same address in the same cycle, clr wins and the entry becomes 0.
  - If they target different addresses, both take effect.
  - clr during CLEAR is ignored (redundant).
- Reads are asynchronous: rd_data_x = entry[rd_addr_x]. Both ports are independent, and both may read the same address.
- Bypass (BYPASS=1): in IDLE, with load=1, wr_addr==rd_addr_x, and no winning clr on that address, rd_data_x = wr_data combinationally.
  - If the clr wins, rd_data_x = 0.
  - BYPASS=0: old value until the edge.
- During CLEAR: both read ports return 0 regardless of counter progress, so the datapath never sees partially cleared state.
- ZERO_REG=1: reads of address 0 return 0 (including bypass), and writes to 0 are dropped. The entry-0 storage may be omitted.
- Width rules: address is always in range since depth is 2**ADDR_W; no out-of-range handling is needed.
  - The counter is ADDR_W+1 bits wide, or uses an explicit last-entry compare, so it never wraps ambiguously.

Decomposition:
- Shared package: state encoding (IDLE=0, CLEAR=1) and default width constants (DATA_W=8, ADDR_W=3), so the datapath and ALU share them.
- Natural sub-module: register_bank_clear_fsm.
  - Contains the state, counter, busy and clear_done.
  - Outputs clear_we and clear_addr to the storage array.
  - The storage, write priority and read/bypass logic stay in register_bank.

Test Plan:
- Reset then read: assert reset, release, read A=3 and B=7 -> both 0; busy=0.
- Write/readback: load 0xA5 to addr 2, then 0x3C to addr 5 -> next cycle rd_a(2)=0xA5, rd_b(5)=0x3C; same-cycle read of addr 2 shows 0xA5 with BYPASS=1 and the old value (0) with BYPASS=0.
- clr vs load collision: entry 4=0x11; same cycle load 0xFF to 4 and clr 4 -> entry 4 = 0x00; bypass read of 4 shows 0x00 in that cycle.
- Sequenced clear, basic: fill all 8 entries with 0x80+i, pulse clear_all -> busy high for 8 cycles, reads return 0 throughout, clear_done pulses once, then all entries read 0.
- Sequenced clear, interactions: load 0x77 to addr 1 issued during CLEAR is dropped (entry 1 reads 0 after); a second clear_all during CLEAR does not extend busy beyond 8 cycles.
- Reset mid-clear: assert reset at counter=3 -> busy drops immediately, no clear_done pulse; a subsequent write of 0x42 to addr 6 reads back 0x42.
- ZERO_REG=1: write 0x99 to addr 0 -> rd(0)=0, including the same-cycle bypass read.
